// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display slice.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_display.sv
// Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
module Display (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Scans a multi-digit hex value across common-anode digits, committing new
// values only at frame boundaries so a frame is never torn.
module display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int DIV_W = clog2(SCAN_DIV);
  localparam int IDX_W = clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;
  logic                    wrapped;
  logic                    tick;
  logic                    boundary;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   an_next;
  logic                    dark;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  // Prescaler, digit index and the double-buffered value; a load landing on
  // the boundary bypasses the shadow so it shows up one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      if (boundary) begin
        if (load) begin
          disp    <= value;
          pending <= 1'b0;
        end else if (pending) begin
          disp    <= shadow;
          pending <= 1'b0;
        end
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end
    end
  end

  // A digit is suppressed while it and everything above it are zero; digit 0
  // always stays lit so zero reads as a single "0".
  always_comb begin
    suppress = '0;
    zero_run = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (disp[4*i +: 4] == 4'h0);
      suppress[i] = zero_run;
    end
  end

  assign nibble  = disp[4*idx +: 4];
  assign dark    = blank_mask[idx] | suppress[idx];
  assign an_next = ~(NUM_DIGITS'(1) << idx);

  Display u_display (
    .hex (nibble),
    .seg (dec_seg)
  );

  // Segments and anodes share one register so both switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      an      <= '1;
      seg     <= SEG_OFF;
      frame   <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      an      <= dark ? '1 : an_next;
      seg     <= dark ? SEG_OFF : dec_seg;
      wrapped <= boundary;
      frame   <= wrapped;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner with 4 digits and a
// 4-cycle scan interval.
module tb_display_scanner;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int vectors;
  int miscompares;
  int cyc;

  display_scanner #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .seg        (seg),
    .an         (an),
    .frame      (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic runTo(input int n);
    while (cyc < n) step();
  endtask

  // Drives a one-cycle load strobe that the next edge captures.
  task automatic applyStimulus(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    step();
    load  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ean,
                             input logic [6:0] eseg, input logic efr);
    vectors++;
    assert ({an, seg, frame} === {ean, eseg, efr}) else begin
      miscompares++;
      $error("[TB] FAIL %s @%0d: observed an=%b seg=%b frame=%b, expected an=%b seg=%b frame=%b",
             tag, cyc, an, seg, frame, ean, eseg, efr);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s @%0d: observed %b, expected %b", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst         = 1'b1;
    load        = 1'b0;
    value       = '0;
    blank_mask  = '0;
    lz_en       = 1'b0;

    repeat (3) step();
    checkOutput("reset", 4'b1111, 7'b1111111, 1'b0);
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("d0_hold", 4'b1110, 7'b1000000, 1'b0);
    end
    step();
    checkOutput("d1_start", 4'b1101, 7'b1000000, 1'b0);
    while (cyc < 16) begin
      step();
      checkBit("frame_low", frame, 1'b0);
    end
    step();
    checkOutput("first_wrap", 4'b1110, 7'b1000000, 1'b1);

    // Mid-frame load: old value holds until the wrap.
    runTo(19);
    applyStimulus(16'hA5C3);
    step();
    checkOutput("old_d1", 4'b1101, 7'b1000000, 1'b0);
    runTo(32);
    checkOutput("old_d3", 4'b0111, 7'b1000000, 1'b0);
    step();
    checkOutput("a5c3_d0", 4'b1110, 7'b0110000, 1'b1);
    runTo(37);
    checkOutput("a5c3_d1", 4'b1101, 7'b1000110, 1'b0);
    runTo(41);
    checkOutput("a5c3_d2", 4'b1011, 7'b0010010, 1'b0);
    runTo(45);
    checkOutput("a5c3_d3", 4'b0111, 7'b0001000, 1'b0);

    // Two loads in one frame: last write wins.
    runTo(49);
    applyStimulus(16'h1111);
    runTo(54);
    applyStimulus(16'h2222);
    runTo(56);
    checkOutput("held_d1", 4'b1101, 7'b1000110, 1'b0);
    runTo(65);
    checkOutput("2222_d0", 4'b1110, 7'b0100100, 1'b1);
    runTo(69);
    checkOutput("2222_d1", 4'b1101, 7'b0100100, 1'b0);
    runTo(73);
    checkOutput("2222_d2", 4'b1011, 7'b0100100, 1'b0);
    runTo(77);
    checkOutput("2222_d3", 4'b0111, 7'b0100100, 1'b0);

    // Load exactly on the boundary edge.
    runTo(79);
    applyStimulus(16'h7654);
    checkOutput("bnd_old_d3", 4'b0111, 7'b0100100, 1'b0);
    checkBit("bnd_pending", dut.pending, 1'b0);
    step();
    checkOutput("bnd_d0", 4'b1110, 7'b0011001, 1'b1);
    runTo(85);
    checkOutput("bnd_d1", 4'b1101, 7'b0010010, 1'b0);

    // Leading-zero suppression.
    runTo(89);
    lz_en = 1'b1;
    applyStimulus(16'h0040);
    runTo(96);
    checkOutput("lz_7654_d3", 4'b0111, 7'b1111000, 1'b0);
    step();
    checkOutput("lz40_d0", 4'b1110, 7'b1000000, 1'b1);
    runTo(101);
    checkOutput("lz40_d1", 4'b1101, 7'b0011001, 1'b0);
    runTo(105);
    checkOutput("lz40_d2", 4'b1111, 7'b1111111, 1'b0);
    applyStimulus(16'h0000);
    runTo(109);
    checkOutput("lz40_d3", 4'b1111, 7'b1111111, 1'b0);
    runTo(113);
    checkOutput("lz0_d0", 4'b1110, 7'b1000000, 1'b1);
    runTo(117);
    checkOutput("lz0_d1", 4'b1111, 7'b1111111, 1'b0);
    runTo(121);
    checkOutput("lz0_d2", 4'b1111, 7'b1111111, 1'b0);
    runTo(125);
    checkOutput("lz0_d3", 4'b1111, 7'b1111111, 1'b0);

    // Blank mask on digit 2, then a mid-frame reset with a load pending.
    lz_en      = 1'b0;
    blank_mask = 4'b0100;
    applyStimulus(16'h89AB);
    runTo(129);
    checkOutput("blk_d0", 4'b1110, 7'b0000011, 1'b1);
    runTo(133);
    checkOutput("blk_d1", 4'b1101, 7'b0001000, 1'b0);
    runTo(137);
    checkOutput("blk_d2", 4'b1111, 7'b1111111, 1'b0);
    runTo(141);
    checkOutput("blk_d3", 4'b0111, 7'b0000000, 1'b0);
    runTo(148);
    applyStimulus(16'h1234);
    runTo(150);
    rst = 1'b1;
    step();
    checkOutput("midrst", 4'b1111, 7'b1111111, 1'b0);
    checkBit("midrst_pending", dut.pending, 1'b0);
    rst = 1'b0;
    cyc = 0;
    step();
    checkOutput("rst_d0", 4'b1110, 7'b1000000, 1'b0);
    runTo(5);
    checkOutput("rst_d1", 4'b1101, 7'b1000000, 1'b0);
    runTo(9);
    checkOutput("rst_d2", 4'b1111, 7'b1111111, 1'b0);
    runTo(13);
    checkOutput("rst_d3", 4'b0111, 7'b1000000, 1'b0);
    runTo(17);
    checkOutput("rst_wrap", 4'b1110, 7'b1000000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
